stream_window_tracker: RTL and testbench

//  Sink-side position decoder for the streaming convolution datapath. Accepts a raster-order

---
 rtl/stream_window_tracker.sv | 157 +++++++++++++++
 tb/tb_stream_window_tracker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stream_window_tracker.sv
// Raster-order position decoder: registers each accepted pixel with its (row, col), frame/line markers and KxK window flag.
// Optional frame abort input is compiled in with `define STREAM_TRACKER_ABORT_EN.
module stream_window_tracker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int K      = 3,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef STREAM_TRACKER_ABORT_EN
    input  logic              frame_abort,
`endif
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_row,
    output logic [CNT_W-1:0]  m_col,
    output logic              m_win_valid,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [FCNT_W-1:0] frame_count
);

    localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0]  w_q, w_d, h_q, h_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  m_row_q, m_row_d, m_col_q, m_col_d;
    logic              m_win_q, m_win_d, m_sof_q, m_sof_d;
    logic              m_eol_q, m_eol_d, m_eof_q, m_eof_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;

    logic              abort;
    logic              accept, consume, at_origin, last_col, last_row;
    logic [CNT_W-1:0]  eff_w, eff_h;

`ifdef STREAM_TRACKER_ABORT_EN
    assign abort = frame_abort;
`else
    assign abort = 1'b0;
`endif

    assign s_ready = (!m_valid_q || m_ready) && !abort;
    assign accept  = s_valid && s_ready;
    assign consume = m_valid_q && m_ready;

    always_comb begin
        at_origin = (row_q == '0) && (col_q == '0);
        // The first pixel of a frame uses live config; the rest use the latched copy.
        eff_w     = at_origin ? ((cfg_width  == '0) ? ONE : cfg_width)  : w_q;
        eff_h     = at_origin ? ((cfg_height == '0) ? ONE : cfg_height) : h_q;
        last_col  = (col_q == eff_w - ONE);
        last_row  = (row_q == eff_h - ONE);

        row_d         = row_q;
        col_d         = col_q;
        w_d           = w_q;
        h_d           = h_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_row_d       = m_row_q;
        m_col_d       = m_col_q;
        m_win_d       = m_win_q;
        m_sof_d       = m_sof_q;
        m_eol_d       = m_eol_q;
        m_eof_d       = m_eof_q;
        frame_count_d = frame_count_q;

        if (abort) begin
            row_d     = '0;
            col_d     = '0;
            m_valid_d = 1'b0;
            m_win_d   = 1'b0;
            m_sof_d   = 1'b0;
            m_eol_d   = 1'b0;
            m_eof_d   = 1'b0;
        end else begin
            if (consume && m_eof_q)
                frame_count_d = frame_count_q + FCNT_W'(1);
            if (accept) begin
                if (at_origin) begin
                    w_d = eff_w;
                    h_d = eff_h;
                end
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                m_row_d   = row_q;
                m_col_d   = col_q;
                m_win_d   = (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
                m_sof_d   = at_origin;
                m_eol_d   = last_col;
                m_eof_d   = last_col && last_row;
                if (last_col) begin
                    col_d = '0;
                    row_d = last_row ? '0 : row_q + ONE;
                end else begin
                    col_d = col_q + ONE;
                end
            end else if (consume) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q         <= '0;
            col_q         <= '0;
            w_q           <= '0;
            h_q           <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_row_q       <= '0;
            m_col_q       <= '0;
            m_win_q       <= 1'b0;
            m_sof_q       <= 1'b0;
            m_eol_q       <= 1'b0;
            m_eof_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            w_q           <= w_d;
            h_q           <= h_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_row_q       <= m_row_d;
            m_col_q       <= m_col_d;
            m_win_q       <= m_win_d;
            m_sof_q       <= m_sof_d;
            m_eol_q       <= m_eol_d;
            m_eof_q       <= m_eof_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_row       = m_row_q;
    assign m_col       = m_col_q;
    assign m_win_valid = m_win_q;
    assign m_sof       = m_sof_q;
    assign m_eol       = m_eol_q;
    assign m_eof       = m_eof_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_stream_window_tracker.sv
// Bench for stream_window_tracker: directed frames plus random traffic against a pixel-index reference model.
module tb_stream_window_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_width, cfg_height;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [7:0]  s_data, m_data;
    logic [15:0] m_row, m_col, frame_count;
    logic        m_win_valid, m_sof, m_eol, m_eof;
`ifdef STREAM_TRACKER_ABORT_EN
    logic        frame_abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_window_tracker #(.DATA_W(8), .CNT_W(16), .K(3), .FCNT_W(16)) dut (
        .clk(clk), .rst(rst),
`ifdef STREAM_TRACKER_ABORT_EN
        .frame_abort(frame_abort),
`endif
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_win_valid(m_win_valid),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .frame_count(frame_count)
    );

    // Reference: position derived from the pixel index within the frame.
    logic        e_valid, e_sof, e_eol, e_eof, e_win;
    logic [7:0]  e_data;
    int          e_row, e_col, idx, fw, fh;
    logic [15:0] e_fc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_win = 0;
        e_data = 0; e_row = 0; e_col = 0; idx = 0; fw = 1; fh = 1; e_fc = 0;
    endtask

    task automatic step();
        logic exp_rdy, acc, cons, ab;
        #1;
        ab = 1'b0;
`ifdef STREAM_TRACKER_ABORT_EN
        ab = frame_abort;
`endif
        exp_rdy = (!e_valid || m_ready) && !ab;
        chk("s_ready", s_ready, exp_rdy);
        acc  = s_valid && exp_rdy;
        cons = e_valid && m_ready;
        if (ab) begin
            idx = 0; e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_win = 0;
        end else begin
            if (cons && e_eof) e_fc = e_fc + 16'd1;
            if (acc) begin
                if (idx == 0) begin
                    fw = (cfg_width  == 0) ? 1 : int'(cfg_width);
                    fh = (cfg_height == 0) ? 1 : int'(cfg_height);
                end
                e_row   = idx / fw;
                e_col   = idx % fw;
                e_sof   = (idx == 0);
                e_eol   = (e_col == fw - 1);
                e_eof   = (idx == fw * fh - 1);
                e_win   = (e_row >= 2) && (e_col >= 2);
                e_data  = s_data;
                e_valid = 1'b1;
                idx     = (idx + 1) % (fw * fh);
            end else if (cons) begin
                e_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", m_valid, e_valid);
        if (e_valid) begin
            chk("m_data", m_data, e_data);
            chk("m_row", m_row, e_row);
            chk("m_col", m_col, e_col);
            chk("m_sof", m_sof, e_sof);
            chk("m_eol", m_eol, e_eol);
            chk("m_eof", m_eof, e_eof);
            chk("m_win_valid", m_win_valid, e_win);
        end
        chk("frame_count", frame_count, e_fc);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        s_valid = v; s_data = d; m_ready = r;
        step();
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_row", m_row, 0);
        chk("rst_m_col", m_col, 0);
        chk("rst_flags", {m_sof, m_eol, m_eof, m_win_valid}, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_s_ready", s_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cfg_width = 16'd4; cfg_height = 16'd3;
        s_valid = 0; s_data = 0; m_ready = 1;
        model_reset();
        async_reset();

        // 4x3 frame, full throughput
        for (int i = 1; i <= 12; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'd0, 1'b1);
        chk("t1_frame_count", frame_count, 1);

        // downstream stall after pixel 5
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd6, 1'b0);
            chk("t2_hold", m_data, 5);
        end
        for (int i = 6; i <= 12; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'd0, 1'b1);

        // width change mid-frame only affects next frame
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) cfg_width = 16'd5;
            drive(1'b1, 8'(i), 1'b1);
        end
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i + 20), 1'b1);
        chk("t3_eol5", m_eol, 1);

        // async reset mid-frame
        cfg_width = 16'd4;
        async_reset();
        for (int i = 1; i <= 7; i++) drive(1'b1, 8'(i), 1'b1);
        async_reset();
        drive(1'b1, 8'd50, 1'b1);
        chk("t4_sof", m_sof, 1);

        // 1x1 frames
        async_reset();
        cfg_width = 16'd1; cfg_height = 16'd1;
        for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b1);
        drive(1'b0, 8'd0, 1'b1);
        chk("t5_frame_count", frame_count, 3);

`ifdef STREAM_TRACKER_ABORT_EN
        cfg_width = 16'd4; cfg_height = 16'd3;
        async_reset();
        for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i), 1'b1);
        frame_abort = 1'b1;
        drive(1'b1, 8'd7, 1'b1);
        frame_abort = 1'b0;
        drive(1'b1, 8'd8, 1'b1);
        chk("t6_sof", m_sof, 1);
`endif

        // randomized traffic, config churn including zero sizes
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) cfg_width  = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) cfg_height = 16'($urandom_range(0, 5));
`ifdef STREAM_TRACKER_ABORT_EN
            frame_abort = ($urandom_range(0, 31) == 0);
`endif
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
